vc_rd_arbiter: RTL and testbench
================================

# vc_rd_arbiter

Read-side arbiter for the two virtual-channel FIFOs (VC0, VC1) of the QoS path. It pops words from the VC FIFOs according to strict VC0 priority and an optional anti-starvation rule, honours a downstream pause, and presents a single registered output stream. It sits between the VC0/VC1 FIFO instances and the destination FIFO stage, driving their read strobes and consuming their `empty` flags and data.

## Interface
- `BW`, 6, data width; matches the VC FIFO width.
- `MAX_BURST`, 4, consecutive VC0 grants allowed while VC1 waits (fairness build only); legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset_L` in 1: reset, asynchronous and active-low.
- `VC0_empty` in 1: VC0 FIFO empty flag.
- `VC1_empty` in 1: VC1 FIFO empty flag.
- `VC0_data_out` in BW: VC0 FIFO read data, valid the cycle after `VC0_rd`.
- `VC1_data_out` in BW: VC1 FIFO read data, valid the cycle after `VC1_rd`.
- `dest_pause` in 1: downstream almost-full; blocks new pops.
- `VC0_rd` out 1: pop strobe to VC0.
- `VC1_rd` out 1: pop strobe to VC1.
- `data_out` out BW: registered output word.
- `valid_out` out 1: `data_out` qualifier, one cycle per word.
- `arb_state` out 2: FSM state, IDLE=0, ACTIVE=1, PAUSE=2.

## Operation
- Grant is combinational from current flags and registered state; at most one of `VC0_rd`/`VC1_rd` is high in any cycle; neither is high when `dest_pause`=1 or in reset.
- Grant rule: VC0 non-empty → `VC0_rd`; else VC1 non-empty → `VC1_rd`; else none.
- Stage 1 registers `sel` (0/1) and `pend`=any rd. Stage 2 captures `sel ? VC1_data_out : VC0_data_out` into `data_out` and sets `valid_out`=`pend`.
- FSM (registered):
  - IDLE: both empty and no word in flight; → ACTIVE when either non-empty and `dest_pause`=0; → PAUSE when `dest_pause`=1.
  - ACTIVE: issuing pops; → PAUSE on `dest_pause`=1; → IDLE when both empty and both pipeline stages empty.
  - PAUSE: no pops; in-flight words (max 2) still drain; → ACTIVE when `dest_pause`=0 and any non-empty, else → IDLE when pipeline empty.
- `dest_pause` overrides everything; the destination almost-full threshold must absorb the 2 in-flight words.
- Empty flag and rd in the same cycle: arbiter never pops an empty FIFO; no underflow possible from this block.

## Timing
- Reset (async, `reset_L`=0): `VC0_rd`=`VC1_rd`=0, `valid_out`=0, `data_out`=0, `arb_state`=IDLE, burst counter=0; in-flight words discarded. Reset released mid-stream restarts from IDLE.
- Latency: pop in cycle N → `valid_out`=1 with that word in cycle N+2.
- Throughput: one word per cycle while unpaused and a FIFO is non-empty.
- Order preserved: words leave in grant order.
- `dest_pause` rising in cycle N: no pop in N; words popped in N-1 and N-2 still appear in N+1 and N.

## Configuration
- `VC_ARB_FAIRNESS_EN` defined: 4-bit `burst_cnt` increments on each VC0 grant while VC1 is non-empty; clears on any VC1 grant or whenever VC1 is empty. When `burst_cnt`==`MAX_BURST` and VC1 non-empty, the next grant goes to VC1 even if VC0 is non-empty, then counter clears. Counter holds during pause.
- Not defined: strict VC0 priority; VC1 served only when VC0 empty; `burst_cnt` and `MAX_BURST` absent.

## Test plan
- Reset: `reset_L`=0 with both FIFOs non-empty → rd strobes 0, `valid_out`=0, `data_out`=0, `arb_state`=0; release → first `VC0_rd` the next cycle.
- VC0 holds 0x01..0x03, VC1 empty → `VC0_rd` 3 cycles, `valid_out` 3 cycles starting 2 cycles later, `data_out`=0x01,0x02,0x03, then `arb_state`=IDLE.
- VC0 holds 8 words, VC1 holds 0x2A, fairness off → all 8 VC0 words then 0x2A; fairness on, `MAX_BURST`=4 → 4 VC0 words, 0x2A, 4 VC0 words.
- `dest_pause` asserted for 5 cycles mid-stream → no rd for 5 cycles, exactly 2 in-flight words emitted, `arb_state`=PAUSE; resume continues with no loss or duplication.
- Only VC1 non-empty (0x15, 0x16) → `VC1_rd` 2 cycles, `data_out`=0x15,0x16, `VC0_rd` never asserted.
- `reset_L` pulsed low with 2 words in flight → outputs cleared immediately, discarded words never appear, next pop occurs after release.

Source files
------------

// File: rtl/vc_rd_arbiter.sv
// vc_rd_arbiter: pops the VC0/VC1 FIFOs into one registered stream; strict VC0 priority, or VC1 anti-starvation when VC_ARB_FAIRNESS_EN is defined.
// Latency: a pop in cycle N shows on data_out/valid_out in cycle N+2; sustains one word per cycle.
// Backpressure: dest_pause blocks new pops in the same cycle; up to 2 words already in flight still drain.
module vc_rd_arbiter #(
    parameter int BW = 6
`ifdef VC_ARB_FAIRNESS_EN
    ,
    parameter int MAX_BURST = 4
`endif
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          VC0_empty,
    input  logic          VC1_empty,
    input  logic [BW-1:0] VC0_data_out,
    input  logic [BW-1:0] VC1_data_out,
    input  logic          dest_pause,
    output logic          VC0_rd,
    output logic          VC1_rd,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
    output logic [1:0]    arb_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic w_vc0_ne;
    logic w_vc1_ne;
    logic w_any_ne;
    logic w_gnt0;
    logic w_gnt1;
    logic w_force_vc1;
    logic w_pipe_empty;
    logic r_run;
    logic r_sel;
    logic r_pend;

    assign w_vc0_ne     = ~VC0_empty;
    assign w_vc1_ne     = ~VC1_empty;
    assign w_any_ne     = w_vc0_ne | w_vc1_ne;
    assign w_pipe_empty = ~r_pend & ~valid_out;

    // Pops are held off until the first clock edge after reset release, so rd strobes
    // are low throughout reset and never depend on the raw reset pin combinationally.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_run <= 1'b0;
        else          r_run <= 1'b1;
    end

`ifdef VC_ARB_FAIRNESS_EN
    logic [3:0] r_burst_cnt;

    // VC1 jumps the queue once VC0 has taken MAX_BURST grants back to back while VC1 waited.
    assign w_force_vc1 = (r_burst_cnt == 4'(MAX_BURST)) && w_vc1_ne;

    // Count consecutive VC0 grants seen by a waiting VC1; frozen while paused.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_burst_cnt <= 4'd0;
        end else if (!dest_pause) begin
            if (w_gnt1 || !w_vc1_ne) r_burst_cnt <= 4'd0;
            else if (w_gnt0)          r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end
`else
    assign w_force_vc1 = 1'b0;
`endif

    // Grant: at most one pop per cycle, never to an empty FIFO, none while paused.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_run && !dest_pause) begin
            if (w_force_vc1)   w_gnt1 = 1'b1;
            else if (w_vc0_ne) w_gnt0 = 1'b1;
            else if (w_vc1_ne) w_gnt1 = 1'b1;
        end
    end

    assign VC0_rd = w_gnt0;
    assign VC1_rd = w_gnt1;

    // Stage 1: remember which VC was popped while the FIFO fetches the word.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sel  <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_sel  <= w_gnt1;
            r_pend <= w_gnt0 | w_gnt1;
        end
    end

    // Stage 2: capture the fetched word from the selected VC into the output register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= r_pend;
            if (r_pend) data_out <= r_sel ? VC1_data_out : VC0_data_out;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state; pause wins over everything, IDLE only once the pipeline has drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (dest_pause)    w_state_nxt = PAUSE;
                else if (w_any_ne) w_state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (dest_pause)                     w_state_nxt = PAUSE;
                else if (!w_any_ne && w_pipe_empty) w_state_nxt = IDLE;
            end
            PAUSE: begin
                if (!dest_pause && w_any_ne)          w_state_nxt = ACTIVE;
                else if (!dest_pause && w_pipe_empty) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign arb_state = r_state;

endmodule

// File: tb/tb_vc_rd_arbiter.sv
// tb_vc_rd_arbiter: directed stimulus with queue-based VC FIFO models and a cycle-level reference model.
// Latency: the model predicts every output word two cycles after its grant.
// Backpressure: dest_pause windows are driven directly; the bench checks rd suppression and in-flight drain.
module tb_vc_rd_arbiter;
    localparam int BW        = 6;
    localparam int MAX_BURST = 4;
`ifdef VC_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_L;
    logic          VC0_empty;
    logic          VC1_empty;
    logic [BW-1:0] VC0_data_out;
    logic [BW-1:0] VC1_data_out;
    logic          dest_pause;
    logic          VC0_rd;
    logic          VC1_rd;
    logic [BW-1:0] data_out;
    logic          valid_out;
    logic [1:0]    arb_state;

    vc_rd_arbiter #(.BW(BW)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .VC0_empty    (VC0_empty),
        .VC1_empty    (VC1_empty),
        .VC0_data_out (VC0_data_out),
        .VC1_data_out (VC1_data_out),
        .dest_pause   (dest_pause),
        .VC0_rd       (VC0_rd),
        .VC1_rd       (VC1_rd),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .arb_state    (arb_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] w;
        int            t;
    } ent_t;

    // FIFO contents, reference model state and observation logs
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] out_log[$];
    int            vld_cyc[$];
    int            rd_cyc[$];
    ent_t          inflight[$];
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            rd0_n, rd1_n, first_rd, first_vld;
    int            m_state = 0;
    int            m_burst = 0;
    bit            m_run = 1'b0;
    bit            s_rd0 = 1'b0;
    bit            s_rd1 = 1'b0;
    bit            e0, e1, ev, pipe_empty, any_ne;
    int            p0, cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model and per-cycle comparison, evaluated mid-cycle on stable signals.
    always @(negedge clk) begin
        s_rd0 = VC0_rd;
        s_rd1 = VC1_rd;
        if (!reset_L) begin
            check("rst_vc0_rd", 32'(VC0_rd), 0);
            check("rst_vc1_rd", 32'(VC1_rd), 0);
            check("rst_valid", 32'(valid_out), 0);
            check("rst_data", 32'(data_out), 0);
            check("rst_state", 32'(arb_state), 0);
            inflight.delete();
            m_state = 0;
            m_burst = 0;
            m_run   = 1'b0;
        end else begin
            any_ne = (q0.size() > 0) || (q1.size() > 0);
            e0 = 1'b0;
            e1 = 1'b0;
            if (m_run && !dest_pause) begin
                if (FAIR && m_burst == MAX_BURST && q1.size() > 0) e1 = 1'b1;
                else if (q0.size() > 0)                              e0 = 1'b1;
                else if (q1.size() > 0)                              e1 = 1'b1;
            end
            pipe_empty = (inflight.size() == 0);
            ev = (inflight.size() > 0) && (inflight[0].t == cyc);
            check("vc0_rd", 32'(VC0_rd), 32'(e0));
            check("vc1_rd", 32'(VC1_rd), 32'(e1));
            check("valid_out", 32'(valid_out), 32'(ev));
            check("arb_state", 32'(arb_state), 32'(m_state));
            if (ev) begin
                check("data_out", 32'(data_out), 32'(inflight[0].w));
                void'(inflight.pop_front());
            end
            if (e0) inflight.push_back(ent_t'{q0[0], cyc + 2});
            if (e1) inflight.push_back(ent_t'{q1[0], cyc + 2});
            if (!dest_pause) begin
                if (e1 || q1.size() == 0) m_burst = 0;
                else if (e0)              m_burst = m_burst + 1;
            end
            case (m_state)
                0:       m_state = dest_pause ? 2 : (any_ne ? 1 : 0);
                1:       m_state = dest_pause ? 2 : ((!any_ne && pipe_empty) ? 0 : 1);
                default: m_state = (!dest_pause && any_ne) ? 1 : ((!dest_pause && pipe_empty) ? 0 : 2);
            endcase
            m_run = 1'b1;
        end
        if (valid_out) begin
            out_log.push_back(data_out);
            vld_cyc.push_back(cyc);
            if (first_vld < 0) first_vld = cyc;
        end
        if (VC0_rd || VC1_rd) begin
            rd_cyc.push_back(cyc);
            if (first_rd < 0) first_rd = cyc;
        end
        if (VC0_rd) rd0_n++;
        if (VC1_rd) rd1_n++;
        cyc++;
    end

    task automatic sync_flags();
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
    endtask

    // Advance n cycles; the FIFO models react to the strobes seen in the cycle just ended.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("no_underflow0", 32'(s_rd0 && q0.size() == 0), 0);
            check("no_underflow1", 32'(s_rd1 && q1.size() == 0), 0);
            if (s_rd0 && q0.size() > 0) VC0_data_out = q0.pop_front();
            if (s_rd1 && q1.size() > 0) VC1_data_out = q1.pop_front();
            sync_flags();
        end
    endtask

    task automatic run_to_idle(input string name);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 80) begin
            tick(1);
            n++;
            done = (arb_state == 2'd0) && (q0.size() == 0) && (q1.size() == 0);
        end
        check({name, "_reached_idle"}, 32'(done), 1);
    endtask

    task automatic clear_logs();
        out_log.delete();
        vld_cyc.delete();
        rd_cyc.delete();
        rd0_n     = 0;
        rd1_n     = 0;
        first_rd  = -1;
        first_vld = -1;
    endtask

    task automatic check_seq(input string name);
        check({name, "_count"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            check({name, "_word"}, 32'(out_log[i]), 32'(exp_q[i]));
    endtask

    initial begin
        reset_L      = 1'b0;
        dest_pause   = 1'b0;
        VC0_data_out = '0;
        VC1_data_out = '0;
        clear_logs();

        // Reset with both FIFOs holding data, then release.
        q0 = '{6'h01, 6'h02, 6'h03};
        q1 = '{6'h15, 6'h16};
        sync_flags();
        tick(3);
        check("t1_rst_rd0", 32'(VC0_rd), 0);
        check("t1_rst_valid", 32'(valid_out), 0);
        check("t1_rst_data", 32'(data_out), 0);
        check("t1_rst_state", 32'(arb_state), 0);
        reset_L = 1'b1;
        tick(1);
        check("t1_first_pop_vc0", 32'(VC0_rd), 1);
        check("t1_first_pop_vc1", 32'(VC1_rd), 0);
        run_to_idle("t1");
        exp_q = '{6'h01, 6'h02, 6'h03, 6'h15, 6'h16};
        check_seq("t1");

        // VC0 only: three pops, three words two cycles later, back to IDLE.
        clear_logs();
        q0 = '{6'h01, 6'h02, 6'h03};
        sync_flags();
        run_to_idle("t2");
        exp_q = '{6'h01, 6'h02, 6'h03};
        check_seq("t2");
        check("t2_rd0_cycles", 32'(rd0_n), 3);
        check("t2_rd1_cycles", 32'(rd1_n), 0);
        check("t2_latency", 32'(first_vld - first_rd), 2);
        check("t2_final_state", 32'(arb_state), 0);

        // VC0 burst with one waiting VC1 word.
        clear_logs();
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};
        q1 = '{6'h2A};
        sync_flags();
        run_to_idle("t3");
`ifdef VC_ARB_FAIRNESS_EN
        exp_q = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h2A, 6'h05, 6'h06, 6'h07, 6'h08};
`else
        exp_q = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h2A};
`endif
        check_seq("t3");

        // Pause for 5 cycles mid-stream.
        clear_logs();
        q0 = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19};
        sync_flags();
        tick(3);
        p0 = cyc;
        dest_pause = 1'b1;
        #1;
        check("t4_pause_blocks_rd", 32'(VC0_rd), 0);
        tick(1);
        check("t4_state_pause", 32'(arb_state), 2);
        tick(4);
        dest_pause = 1'b0;
        run_to_idle("t4");
        cnt = 0;
        foreach (rd_cyc[i]) if (rd_cyc[i] >= p0 && rd_cyc[i] <= p0 + 4) cnt++;
        check("t4_rd_in_pause", 32'(cnt), 0);
        cnt = 0;
        foreach (vld_cyc[i]) if (vld_cyc[i] >= p0 && vld_cyc[i] <= p0 + 4) cnt++;
        check("t4_drained_in_pause", 32'(cnt), 2);
        exp_q = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16, 6'h17, 6'h18, 6'h19};
        check_seq("t4");

        // VC1 only.
        clear_logs();
        q1 = '{6'h15, 6'h16};
        sync_flags();
        run_to_idle("t5");
        exp_q = '{6'h15, 6'h16};
        check_seq("t5");
        check("t5_rd0_cycles", 32'(rd0_n), 0);
        check("t5_rd1_cycles", 32'(rd1_n), 2);

        // Reset pulse with two words in flight: they are dropped, popping resumes after release.
        clear_logs();
        q0 = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25};
        sync_flags();
        tick(2);
        reset_L = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid_out), 0);
        check("t6_rst_data", 32'(data_out), 0);
        check("t6_rst_rd0", 32'(VC0_rd), 0);
        check("t6_rst_state", 32'(arb_state), 0);
        tick(2);
        reset_L = 1'b1;
        tick(1);
        check("t6_pop_after_release", 32'(VC0_rd), 1);
        run_to_idle("t6");
        exp_q = '{6'h23, 6'h24, 6'h25};
        check_seq("t6");

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
